cache_port_arbiter: RTL

//  Shares the single cache request port (c_addr/c_wdata/c_bval/c_rd/c_wr/c_rdata/c_ack) among NREQ requesters in the c_clk domain.

---
 rtl/cache_arb_pkg.sv | 15 +
 rtl/cache_port_arbiter_rr_pick.sv | 35 +++
 rtl/cache_port_arbiter.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/cache_arb_pkg.sv
// Shared definitions for the cache port arbiter: FSM state encoding and
// the widths of the cache request port fields.
package cache_arb_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int BVAL_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RECOVER = 2'd2
  } arb_state_e;

endpackage

// File: rtl/cache_port_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority picker. Returns the first
// pending requester found searching upward from rr_ptr_i with wrap-around.
// rr_ptr_i is always < NREQ, so indices >= NREQ can never be produced.
module rr_pick #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic [NREQ-1:0] pending_i,
  input  logic [IDW-1:0]  rr_ptr_i,
  output logic [IDW-1:0]  idx_o,
  output logic            any_o
);

  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  logic [IDW-1:0]    off;
  logic [IDW:0]      sum;

  // Rotate the pending vector so bit 0 is the requester at rr_ptr_i.
  assign dbl = {pending_i, pending_i};
  assign rot = NREQ'(dbl >> rr_ptr_i);

  // Lowest set bit of the rotated vector is the winner; map back modulo NREQ.
  always_comb begin
    any_o = |rot;
    off   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) off = IDW'(k);
    end
    sum = {1'b0, rr_ptr_i} + {1'b0, off};
    if (sum >= (IDW+1)'(NREQ)) sum = sum - (IDW+1)'(NREQ);
    idx_o = sum[IDW-1:0];
  end

endmodule

// File: rtl/cache_port_arbiter.sv
// cache_port_arbiter: shares one cache request port among NREQ requesters
// in the cache clock domain. Round-robin grant, one transaction in flight,
// all outputs registered. FSM: IDLE -> ISSUE -> RECOVER -> IDLE.
// Optional feature macro: ARB_TIMEOUT_EN adds an ISSUE watchdog that aborts
// the transaction after TIMEOUT_CYC cycles and flags req_err.
module cache_port_arbiter
  import cache_arb_pkg::*;
#(
  parameter int NREQ        = 2,
  parameter int IDW         = 1,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                     c_clk,
  input  logic                     Reset,
  input  logic [NREQ-1:0]          req_rd,
  input  logic [NREQ-1:0]          req_wr,
  input  logic [ADDR_W*NREQ-1:0]   req_addr,
  input  logic [DATA_W*NREQ-1:0]   req_wdata,
  input  logic [BVAL_W*NREQ-1:0]   req_bval,
  output logic [NREQ-1:0]          req_ack,
  output logic [DATA_W-1:0]        req_rdata,
  output logic                     req_err,
  output logic                     busy,
  output logic [IDW-1:0]           grant_id,
  output logic [ADDR_W-1:0]        c_addr,
  output logic [DATA_W-1:0]        c_wdata,
  output logic [BVAL_W-1:0]        c_bval,
  output logic                     c_rd,
  output logic                     c_wr,
  input  logic [DATA_W-1:0]        c_rdata,
  input  logic                     c_ack
);

  arb_state_e          state_q;
  logic [ADDR_W-1:0]   c_addr_q;
  logic [DATA_W-1:0]   c_wdata_q;
  logic [BVAL_W-1:0]   c_bval_q;
  logic                c_rd_q;
  logic                c_wr_q;
  logic [NREQ-1:0]     req_ack_q;
  logic [DATA_W-1:0]   req_rdata_q;
  logic [IDW-1:0]      grant_q;
  logic [IDW-1:0]      rr_ptr_q;

  logic [NREQ-1:0]     pending;
  logic [IDW-1:0]      pick_idx;
  logic                pick_any;
  logic [ADDR_W-1:0]   sel_addr_d;
  logic [DATA_W-1:0]   sel_wdata_d;
  logic [BVAL_W-1:0]   sel_bval_d;
  logic                sel_rd_d;
  logic                sel_wr_d;
  logic [IDW-1:0]      rr_ptr_d;

`ifdef ARB_TIMEOUT_EN
  localparam int TMO_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
  logic [TMO_W-1:0]    tmo_q;
  logic                req_err_q;
`else
  // TIMEOUT_CYC only has meaning in the watchdog build.
  logic                unused_cfg;
  assign unused_cfg = ^TIMEOUT_CYC;
`endif

  // A request with both rd and wr set counts once and is served as a read.
  assign pending = req_rd | req_wr;

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .pending_i (pending),
    .rr_ptr_i  (rr_ptr_q),
    .idx_o     (pick_idx),
    .any_o     (pick_any)
  );

  // Route the picked requester's fields and compute the next round-robin start.
  always_comb begin
    sel_addr_d  = '0;
    sel_wdata_d = '0;
    sel_bval_d  = '0;
    sel_rd_d    = 1'b0;
    sel_wr_d    = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_idx == IDW'(i)) begin
        sel_addr_d  = req_addr[ADDR_W*i +: ADDR_W];
        sel_wdata_d = req_wdata[DATA_W*i +: DATA_W];
        sel_bval_d  = req_bval[BVAL_W*i +: BVAL_W];
        sel_rd_d    = req_rd[i];
        sel_wr_d    = req_wr[i] & ~req_rd[i];
      end
    end
    rr_ptr_d = (pick_idx == IDW'(NREQ - 1)) ? '0 : pick_idx + IDW'(1);
  end

  // Arbitration FSM with all cache-side and requester-side outputs registered.
  always_ff @(posedge c_clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      c_addr_q    <= '0;
      c_wdata_q   <= '0;
      c_bval_q    <= '0;
      c_rd_q      <= 1'b0;
      c_wr_q      <= 1'b0;
      req_ack_q   <= '0;
      req_rdata_q <= '0;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
`ifdef ARB_TIMEOUT_EN
      tmo_q       <= '0;
      req_err_q   <= 1'b0;
`endif
    end else begin
      // req_ack / req_err are single-cycle pulses.
      req_ack_q <= '0;
`ifdef ARB_TIMEOUT_EN
      req_err_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            c_addr_q  <= sel_addr_d;
            c_wdata_q <= sel_wdata_d;
            c_bval_q  <= sel_bval_d;
            c_rd_q    <= sel_rd_d;
            c_wr_q    <= sel_wr_d;
            grant_q   <= pick_idx;
            rr_ptr_q  <= rr_ptr_d;
            state_q   <= ISSUE;
`ifdef ARB_TIMEOUT_EN
            tmo_q     <= '0;
`endif
          end
        end
        ISSUE: begin
          // c_ack wins over a coinciding watchdog expiry.
          if (c_ack) begin
            req_rdata_q        <= c_rdata;
            req_ack_q[grant_q] <= 1'b1;
            c_rd_q             <= 1'b0;
            c_wr_q             <= 1'b0;
            state_q            <= RECOVER;
          end
`ifdef ARB_TIMEOUT_EN
          else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
            req_rdata_q        <= '0;
            req_ack_q[grant_q] <= 1'b1;
            req_err_q          <= 1'b1;
            c_rd_q             <= 1'b0;
            c_wr_q             <= 1'b0;
            state_q            <= RECOVER;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
`endif
        end
        RECOVER: begin
          // Guaranteed idle gap at the cache before the next grant.
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign c_addr    = c_addr_q;
  assign c_wdata   = c_wdata_q;
  assign c_bval    = c_bval_q;
  assign c_rd      = c_rd_q;
  assign c_wr      = c_wr_q;
  assign req_ack   = req_ack_q;
  assign req_rdata = req_rdata_q;
  assign grant_id  = grant_q;
  assign busy      = (state_q != IDLE);
`ifdef ARB_TIMEOUT_EN
  assign req_err   = req_err_q;
`else
  assign req_err   = 1'b0;
`endif

endmodule
